// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares a single-port, combinationally-read instruction ROM between two
// requesters: instruction fetch (IF) and data load (D, lw from instruction
// space). Byte addresses are converted to word addresses, checked for alignment
// and window range, and the ROM word is registered (1-cycle read latency).
// D normally wins a contested cycle; after MAX_STREAK consecutive contested D
// grants, IF is owed the next grant so fetch always makes progress.
//
// Parameters
//   ADDR_W      ROM word-address width (2**ADDR_W words)
//   BASE        byte base address of the ROM window (2**(ADDR_W+2)-aligned)
//   MAX_STREAK  consecutive contested D grants before IF is forced (1..15)
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   reset      in   synchronous, active-high reset
//   if_req     in   IF read request, held with if_addr until if_gnt
//   if_addr    in   IF byte address (32 bits)
//   if_gnt     out  IF request accepted this cycle (combinational)
//   if_valid   out  IF read data/err valid, one cycle after if_gnt
//   if_rdata   out  IF read data (holds until next IF valid)
//   if_err     out  IF access was misaligned or outside the window
//   d_req      in   D read request, held with d_addr until d_gnt
//   d_addr     in   D byte address (32 bits)
//   d_gnt      out  D request accepted this cycle (combinational)
//   d_valid    out  D read data/err valid, one cycle after d_gnt
//   d_rdata    out  D read data (holds until next D valid)
//   d_err      out  D access was misaligned or outside the window
//   rom_addr   out  word address to the ROM (combinational)
//   rom_instr  in   ROM data, combinational from rom_addr
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
   parameter int          ADDR_W     = 5,
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter int          MAX_STREAK = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic [31:0]       d_addr,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_instr
);

   localparam logic [31:0] WIN_BYTES = 32'(1) << (ADDR_W + 2);
   localparam logic [3:0]  MAX_S     = 4'(MAX_STREAK);

   typedef enum logic {D_PRI, FETCH_OWED} state_t;

   state_t      state, state_next;
   logic [3:0]  streak, streak_next;

   logic        if_valid_q, d_valid_q;
   logic        if_err_q, d_err_q;
   logic [31:0] if_rdata_q, d_rdata_q;
   logic        if_bad, d_bad;

   // Misaligned, or outside the window. The subtraction wraps for addresses
   // below BASE, so one unsigned compare covers both sides of the window.
   function automatic logic addr_bad(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a[1:0] != 2'b00) || (off >= WIN_BYTES);
   endfunction

   assign if_bad = addr_bad(if_addr);
   assign d_bad  = addr_bad(d_addr);

   // With no grant the ROM still sees the D address bits.
   assign rom_addr = if_gnt ? if_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];

   // Grant selection and streak / state update.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      state_next  = state;
      streak_next = streak;
      if (!reset) begin
         unique case (state)
            D_PRI: begin
               if (d_req && if_req) begin
                  d_gnt       = 1'b1;
                  streak_next = streak + 4'd1;
                  if (streak + 4'd1 >= MAX_S) state_next = FETCH_OWED;
               end else if (d_req) begin
                  d_gnt       = 1'b1;
                  streak_next = 4'd0;
               end else if (if_req) begin
                  if_gnt      = 1'b1;
                  streak_next = 4'd0;
               end
            end
            FETCH_OWED: begin
               // IF keeps priority until it is actually served.
               if (if_req) begin
                  if_gnt      = 1'b1;
                  streak_next = 4'd0;
                  state_next  = D_PRI;
               end else if (d_req) begin
                  d_gnt = 1'b1;
               end
            end
            default: state_next = D_PRI;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state      <= D_PRI;
         streak     <= 4'd0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_err_q   <= 1'b0;
         d_err_q    <= 1'b0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
      end else begin
         state      <= state_next;
         streak     <= streak_next;
         if_valid_q <= if_gnt;
         d_valid_q  <= d_gnt;
         if_err_q   <= if_gnt & if_bad;
         d_err_q    <= d_gnt & d_bad;
         if (if_gnt) if_rdata_q <= if_bad ? 32'h0 : rom_instr;
         if (d_gnt)  d_rdata_q  <= d_bad  ? 32'h0 : rom_instr;
      end
   end

   // A grant taken in the cycle before reset would otherwise surface as a
   // valid during the reset cycle; mask the response outputs while reset is
   // high so the whole response side reads zero.
   assign if_valid = if_valid_q & ~reset;
   assign d_valid  = d_valid_q  & ~reset;
   assign if_err   = if_err_q   & ~reset;
   assign d_err    = d_err_q    & ~reset;
   assign if_rdata = reset ? 32'h0 : if_rdata_q;
   assign d_rdata  = reset ? 32'h0 : d_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
//
// Directed bench for rom_port_arbiter (default parameters: ADDR_W=5, BASE=0,
// MAX_STREAK=3). A small combinational ROM array drives rom_instr. Inputs are
// driven 1 time unit after the rising edge; grants are sampled 1 unit later and
// registered responses 1 unit after the following edge.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req, d_req;
   logic [31:0] if_addr, d_addr;
   logic        if_gnt, if_valid, if_err;
   logic        d_gnt, d_valid, d_err;
   logic [31:0] if_rdata, d_rdata;
   logic [4:0]  rom_addr;
   logic [31:0] rom_instr;

   logic [31:0] rom_mem [32];

   integer errors = 0;
   integer checks = 0;

   rom_port_arbiter #(
      .ADDR_W(5), .BASE(32'h0), .MAX_STREAK(3)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
      .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
      .rom_addr(rom_addr), .rom_instr(rom_instr)
   );

   assign rom_instr = rom_mem[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h0; d_addr = 32'h0;
      #1;
      checks++;
      if ({if_gnt, d_gnt} !== 2'b00) begin
         errors++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt});
      end
      next_cycle();
      next_cycle();
      reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
      #1;
      checks++;
      if ({if_valid, d_valid, if_err, d_err, if_rdata, d_rdata} !== 68'h0) begin
         errors++; $display("FAIL reset_outputs: got v=%b%b e=%b%b rd=%h/%h expected all 0",
                            if_valid, d_valid, if_err, d_err, if_rdata, d_rdata);
      end
   endtask

   task automatic test_if_single();
      next_cycle();
      if_req = 1'b1; if_addr = 32'h0;
      #1;
      checks++;
      if ({if_gnt, d_gnt, rom_addr} !== {2'b10, 5'd0}) begin
         errors++; $display("FAIL if_single_gnt: got gnt=%b%b rom_addr=%0d expected 10/0",
                            if_gnt, d_gnt, rom_addr);
      end
      next_cycle();
      if_req = 1'b0;
      checks++;
      if ({if_valid, d_valid, if_err, if_rdata} !== {3'b100, 32'h24010001}) begin
         errors++; $display("FAIL if_single_data: got v=%b%b e=%b rd=%h expected 10/0/24010001",
                            if_valid, d_valid, if_err, if_rdata);
      end
      next_cycle();
      checks++;
      if ({if_valid, if_rdata} !== {1'b0, 32'h24010001}) begin
         errors++; $display("FAIL if_hold: got v=%b rd=%h expected 0/24010001", if_valid, if_rdata);
      end
   endtask

   task automatic test_d_single();
      d_req = 1'b1; d_addr = 32'h14;
      #1;
      checks++;
      if ({if_gnt, d_gnt, rom_addr} !== {2'b01, 5'd5}) begin
         errors++; $display("FAIL d_single_gnt: got gnt=%b%b rom_addr=%0d expected 01/5",
                            if_gnt, d_gnt, rom_addr);
      end
      next_cycle();
      d_req = 1'b0;
      checks++;
      if ({d_valid, if_valid, d_err, d_rdata} !== {3'b100, 32'h0BFFFFD0}) begin
         errors++; $display("FAIL d_single_data: got v=%b%b e=%b rd=%h expected 10/0/0bffffd0",
                            d_valid, if_valid, d_err, d_rdata);
      end
   endtask

   task automatic test_streak();
      // Expected grant owner per cycle, 1 = IF: D,D,D,IF,D,D,D,IF
      logic [7:0] pat;
      pat = 8'b1000_1000;
      next_cycle();
      if_req = 1'b1; if_addr = 32'h8;
      d_req  = 1'b1; d_addr  = 32'h10;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({if_gnt, d_gnt} !== {pat[i], ~pat[i]}) begin
            errors++; $display("FAIL streak_gnt[%0d]: got %b%b expected %b%b",
                               i, if_gnt, d_gnt, pat[i], ~pat[i]);
         end
         next_cycle();
         checks++;
         if (pat[i]) begin
            if ({if_valid, d_valid, if_rdata} !== {2'b10, rom_mem[2]}) begin
               errors++; $display("FAIL streak_if_data[%0d]: got v=%b%b rd=%h expected 10/%h",
                                  i, if_valid, d_valid, if_rdata, rom_mem[2]);
            end
         end else begin
            if ({if_valid, d_valid, d_rdata} !== {2'b01, rom_mem[4]}) begin
               errors++; $display("FAIL streak_d_data[%0d]: got v=%b%b rd=%h expected 01/%h",
                                  i, if_valid, d_valid, d_rdata, rom_mem[4]);
            end
         end
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_errors();
      next_cycle();
      // Misaligned D access
      d_req = 1'b1; d_addr = 32'h6;
      #1;
      checks++;
      if (d_gnt !== 1'b1) begin
         errors++; $display("FAIL err_mis_gnt: got %b expected 1", d_gnt);
      end
      next_cycle();
      checks++;
      if ({d_valid, d_err, d_rdata} !== {2'b11, 32'h0}) begin
         errors++; $display("FAIL err_misaligned: got v=%b e=%b rd=%h expected 1/1/0",
                            d_valid, d_err, d_rdata);
      end
      // Out-of-window D contested with an IF read
      d_addr = 32'h80; if_req = 1'b1; if_addr = 32'h4;
      #1;
      checks++;
      if ({if_gnt, d_gnt, rom_addr} !== {2'b01, 5'd0}) begin
         errors++; $display("FAIL err_oow_gnt: got gnt=%b%b rom_addr=%0d expected 01/0",
                            if_gnt, d_gnt, rom_addr);
      end
      next_cycle();
      d_req = 1'b0;
      checks++;
      if ({d_valid, d_err, if_valid, d_rdata} !== {3'b110, 32'h0}) begin
         errors++; $display("FAIL err_out_of_window: got v=%b e=%b ifv=%b rd=%h expected 1/1/0/0",
                            d_valid, d_err, if_valid, d_rdata);
      end
      next_cycle();
      if_req = 1'b0;
      checks++;
      if ({if_valid, if_err, d_valid, d_err, if_rdata} !== {4'b1000, rom_mem[1]}) begin
         errors++; $display("FAIL err_if_unaffected: got v=%b e=%b dv=%b de=%b rd=%h expected 1/0/0/0/%h",
                            if_valid, if_err, d_valid, d_err, if_rdata, rom_mem[1]);
      end
      // Last word of the window is legal
      d_req = 1'b1; d_addr = 32'h7C;
      next_cycle();
      d_req = 1'b0;
      checks++;
      if ({d_valid, d_err, d_rdata} !== {2'b10, rom_mem[31]}) begin
         errors++; $display("FAIL err_last_word: got v=%b e=%b rd=%h expected 1/0/%h",
                            d_valid, d_err, d_rdata, rom_mem[31]);
      end
      // Misaligned IF access
      if_req = 1'b1; if_addr = 32'h2;
      next_cycle();
      if_req = 1'b0;
      checks++;
      if ({if_valid, if_err, if_rdata} !== {2'b11, 32'h0}) begin
         errors++; $display("FAIL err_if_misaligned: got v=%b e=%b rd=%h expected 1/1/0",
                            if_valid, if_err, if_rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] pat;
      pat = 4'b1000;
      next_cycle();
      if_req = 1'b1; if_addr = 32'h8;
      d_req  = 1'b1; d_addr  = 32'h10;
      // Three contested D grants: the last is cycle N and leaves IF owed.
      for (int i = 0; i < 3; i++) next_cycle();
      reset = 1'b1;
      #1;
      checks++;
      if ({if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, if_rdata, d_rdata} !== 70'h0) begin
         errors++; $display("FAIL reset_mid: got g=%b%b v=%b%b e=%b%b rd=%h/%h expected all 0",
                            if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, if_rdata, d_rdata);
      end
      next_cycle();
      reset = 1'b0;
      // FSM and streak must restart: D,D,D,IF
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({if_gnt, d_gnt} !== {pat[i], ~pat[i]}) begin
            errors++; $display("FAIL reset_mid_gnt[%0d]: got %b%b expected %b%b",
                               i, if_gnt, d_gnt, pat[i], ~pat[i]);
         end
         next_cycle();
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      next_cycle();
      if_req = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if_addr = 32'(i) * 32'd4;
         #1;
         checks++;
         if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, if_gnt);
         end
         next_cycle();
         checks++;
         if ({if_valid, if_err, if_rdata} !== {2'b10, rom_mem[i]}) begin
            errors++; $display("FAIL b2b_data[%0d]: got v=%b e=%b rd=%h expected 1/0/%h",
                               i, if_valid, if_err, if_rdata, rom_mem[i]);
         end
      end
      if_req = 1'b0;
      // A D request withdrawn before the edge issues nothing.
      d_req = 1'b1; d_addr = 32'h0;
      #2;
      d_req = 1'b0;
      next_cycle();
      checks++;
      if ({if_valid, d_valid, if_rdata} !== {2'b00, rom_mem[23]}) begin
         errors++; $display("FAIL b2b_idle: got v=%b%b rd=%h expected 00/%h",
                            if_valid, d_valid, if_rdata, rom_mem[23]);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 32'hC0DE_0000 | 32'(i);
      rom_mem[0] = 32'h24010001;
      rom_mem[5] = 32'h0BFFFFD0;
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = 32'h0; d_addr = 32'h0;
      @(posedge clk);
      #1;
      test_reset();
      test_if_single();
      test_d_single();
      test_streak();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
